// File: rtl/biu_constants_pkg.sv
// Shared BIU transfer attribute types and arbiter master identifiers.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BIU_SIZE_BYTE  = 3'd0,
        BIU_SIZE_HWORD = 3'd1,
        BIU_SIZE_WORD  = 3'd2,
        BIU_SIZE_DWORD = 3'd3,
        BIU_SIZE_QWORD = 3'd4
    } biu_size_t;

    typedef enum logic [1:0] {
        BIU_TYPE_SINGLE = 2'd0,
        BIU_TYPE_INCR   = 2'd1,
        BIU_TYPE_WRAP4  = 2'd2,
        BIU_TYPE_INCR4  = 2'd3
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t BIU_PROT_DATA       = 3'b001;
    localparam biu_prot_t BIU_PROT_INSTR      = 3'b000;
    localparam biu_prot_t BIU_PROT_PRIVILEGED = 3'b010;

    localparam logic BIU_ARB_DATA = 1'b0;
    localparam logic BIU_ARB_INST = 1'b1;

endpackage

// File: rtl/riscv_biu_arb_idq.sv
// In-order ID queue for the BIU arbiter: one bit per outstanding transfer
// naming the master that issued it.
module riscv_biu_arb_idq #(
    parameter int DEPTH = 2
) (
    input  logic rst_ni,
    input  logic clk_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mem_q [DEPTH];
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (DEPTH == 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read while count marks it valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/riscv_biu_arbiter.sv
// Two-master BIU arbiter (0 = data, 1 = instruction) with in-order response routing.
// Define RISCV_BIU_ARB_RR_EN for round-robin arbitration; default is fixed priority to master 0.
module riscv_biu_arbiter
    import biu_constants_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALEN  = XLEN,
    parameter int DEPTH = 2
) (
    input  logic            rst_ni,
    input  logic            clk_i,

    input  logic            m_stb_i     [2],
    input  logic [ALEN-1:0] m_adri_i    [2],
    input  biu_size_t       m_size_i    [2],
    input  biu_type_t       m_type_i    [2],
    input  logic            m_lock_i    [2],
    input  logic            m_we_i      [2],
    input  biu_prot_t       m_prot_i    [2],
    input  logic [XLEN-1:0] m_d_i       [2],
    output logic            m_stb_ack_o [2],
    output logic [ALEN-1:0] m_adro_o    [2],
    output logic [XLEN-1:0] m_q_o       [2],
    output logic            m_d_ack_o   [2],
    output logic            m_ack_o     [2],
    output logic            m_err_o     [2],

    output logic            biu_stb_o,
    output logic [ALEN-1:0] biu_adri_o,
    output biu_size_t       biu_size_o,
    output biu_type_t       biu_type_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output biu_prot_t       biu_prot_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i,
    input  logic [ALEN-1:0] biu_adro_i,
    input  logic [XLEN-1:0] biu_q_i
);

    logic grant;
    logic owner_q, owner_d;
    logic owner_hold_q, owner_hold_d;
    logic lock_q, lock_d;
    logic accept, pop, stall;
    logic head, full, empty;
`ifdef RISCV_BIU_ARB_RR_EN
    logic last_q, last_d;
`endif

    always_comb begin
        if (owner_hold_q) begin
            grant = owner_q;
        end else begin
`ifdef RISCV_BIU_ARB_RR_EN
            if (m_stb_i[BIU_ARB_DATA] && m_stb_i[BIU_ARB_INST]) grant = ~last_q;
            else if (m_stb_i[BIU_ARB_INST])                      grant = BIU_ARB_INST;
            else                                                 grant = BIU_ARB_DATA;
`else
            grant = (!m_stb_i[BIU_ARB_DATA] && m_stb_i[BIU_ARB_INST]) ? BIU_ARB_INST : BIU_ARB_DATA;
`endif
        end
    end

    // A response popping a full queue frees the slot for a new request in the same cycle.
    assign pop    = (biu_ack_i || biu_err_i) && !empty;
    assign stall  = full && !pop;
    assign accept = biu_stb_o && biu_stb_ack_i;

    assign biu_stb_o  = m_stb_i[grant] && !stall;
    assign biu_adri_o = m_adri_i[grant];
    assign biu_size_o = m_size_i[grant];
    assign biu_type_o = m_type_i[grant];
    assign biu_lock_o = m_lock_i[grant];
    assign biu_we_o   = m_we_i[grant];
    assign biu_prot_o = m_prot_i[grant];
    assign biu_d_o    = m_d_i[grant];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_stb_ack_o[i] = accept && (grant == 1'(i));
            m_ack_o[i]     = biu_ack_i && !empty && (head == 1'(i));
            m_err_o[i]     = biu_err_i && !empty && (head == 1'(i));
            m_d_ack_o[i]   = biu_d_ack_i && !empty && (head == 1'(i));
            m_adro_o[i]    = biu_adro_i;
            m_q_o[i]       = biu_q_i;
        end
    end

    // Grant sticks while a request waits for acceptance or a locked sequence is open.
    always_comb begin
        owner_d      = grant;
        lock_d       = accept ? m_lock_i[grant] : lock_q;
        owner_hold_d = lock_d || (m_stb_i[grant] && !accept);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q      <= BIU_ARB_DATA;
            owner_hold_q <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            owner_hold_q <= owner_hold_d;
            lock_q       <= lock_d;
        end
    end

`ifdef RISCV_BIU_ARB_RR_EN
    assign last_d = accept ? grant : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= BIU_ARB_INST;
        else         last_q <= last_d;
    end
`endif

    riscv_biu_arb_idq #(
        .DEPTH (DEPTH)
    ) u_idq (
        .rst_ni  (rst_ni),
        .clk_i   (clk_i),
        .push_i  (accept),
        .pop_i   (pop),
        .din_i   (grant),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    resp_without_transfer_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(empty && (biu_ack_i || biu_err_i || biu_d_ack_i)))
        else $warning("biu response with no outstanding transfer was dropped");

endmodule

// File: doc/riscv_biu_arbiter.md
# riscv_biu_arbiter

Two-master arbiter that shares one BIU port between the data-side core (master 0, e.g. the no-dcache core) and the instruction-side core (master 1). It sits between the CPU memory cores and the BIU. Each master sees a private BIU-style handshake. The arbiter tracks issued-but-unacknowledged transfers so that every data acknowledge or error returns to the master that issued the address. Pipelined BIU transfers from both masters may be outstanding at once; they complete in issue order.

## Interface
Parameters:
- XLEN, 32, data width
- ALEN, XLEN, address width
- DEPTH, 2, maximum outstanding transfers; power of 2, ≥1

Ports. `[2]` means an unpacked array indexed by master: 0 = data, 1 = instruction.
- rst_ni  in  1  asynchronous active-low reset
- clk_i  in  1  clock, all state on rising edge
- m_stb_i  in  [2]  master transfer request
- m_adri_i / m_size_i / m_type_i / m_lock_i / m_we_i / m_prot_i / m_d_i  in  [2]×(ALEN, biu_size_t, biu_type_t, 1, 1, biu_prot_t, XLEN)  master transfer attributes
- m_stb_ack_o  out  [2]  address accepted for that master
- m_adro_o  out  [2]×ALEN  downstream biu_adro_i, broadcast
- m_q_o  out  [2]×XLEN  downstream biu_q_i, broadcast
- m_d_ack_o / m_ack_o / m_err_o  out  [2]  routed write-data ack, data ack, data error
- biu_stb_o / biu_adri_o / biu_size_o / biu_type_o / biu_lock_o / biu_we_o / biu_prot_o / biu_d_o  out  downstream request, taken from the granted master
- biu_stb_ack_i / biu_d_ack_i / biu_ack_i / biu_err_i / biu_adro_i / biu_q_i  in  downstream responses

## Operation
- Grant selection:
  - If `owner_hold` is set, the grant is `owner`.
  - Otherwise the arbitration policy chooses among the masters asserting m_stb_i (see Configuration).
- `owner_hold` is set when the granted master's stb is high and biu_stb_ack_i is low. This keeps the attributes stable until acceptance.
- `owner_hold` is also set after a stb_ack with m_lock_i high. Lock holds the grant until the owner presents a transfer with lock low and that transfer is acked.
- biu_stb_o = m_stb_i[grant] & ~full. All biu_* request outputs are multiplexed from the granted master.
- m_stb_ack_o[grant] = biu_stb_ack_i. The other master sees 0.
- Push: on biu_stb_ack_i, grant (1 bit) is pushed into the ID FIFO.
- Pop: on biu_ack_i | biu_err_i, the ID FIFO head is popped.
  - biu_ack_i / biu_err_i route to m_ack_o[head] / m_err_o[head] only.
  - biu_d_ack_i routes to m_d_ack_o[head].
- Push and pop in the same cycle: count unchanged, head advances.
- Full (count == DEPTH): biu_stb_o is forced to 0. The grant is kept; the master waits.
- Empty: any ack/err/d_ack from downstream is dropped, with no master response. This is a protocol violation and is flagged by an assertion.
- Error: the FIFO entry is popped exactly like ack. The arbiter does not flush other entries. Discarding outstanding transfers is the master core's job.

## Timing
- Request path is combinational, zero latency: m_stb_i → biu_stb_o, biu_stb_ack_i → m_stb_ack_o.
- Response routing is combinational from the registered FIFO head.
- Reset values:
  - owner = 0, owner_hold = 0, last = 1, FIFO count = 0, pointers = 0.
  - biu_stb_o = 0 while m_stb_i = 0.
  - m_ack_o, m_err_o, m_d_ack_o = 0.
- Reset mid-operation clears the FIFO and the lock. Downstream responses arriving afterwards hit an empty FIFO and are dropped.
- Counters are $clog2(DEPTH)+1 bits wide. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Configuration
- RISCV_BIU_ARB_RR_EN defined: round-robin arbitration. Register `last` records the master granted at the most recent stb_ack. When both masters request and no hold is active, the master ≠ last wins.
- RISCV_BIU_ARB_RR_EN undefined: fixed priority, master 0 (data) wins. `last` is not implemented.

## Structure
- biu_size_t, biu_type_t and biu_prot_t come from biu_constants_pkg.
- New shared constants go in biu_constants_pkg: BIU_ARB_DATA = 0, BIU_ARB_INST = 1.
- One sub-module, riscv_biu_arb_idq: synchronous 1-bit-wide FIFO, DEPTH entries.
  - Ports: push, pop, din, head, full, empty.
  - Async active-low clear.

## Test plan
- Single read, master 1 only:
  - Stimulus: stb with adr 0x100; stb_ack in cycle 0; ack in cycle 2.
  - Required: m_ack_o[1] = 1 in cycle 2; m_ack_o[0] = 0 throughout.
- Contention with both masters requesting every cycle, DEPTH = 2, downstream stb_ack always high:
  - With RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: grants are 0,0,0.
- Pipelined mixed traffic:
  - Stimulus: master 0 stb_ack, then master 1 stb_ack, then two acks.
  - Required: the first ack goes to m_ack_o[0], the second to m_ack_o[1].
  - The acks carry biu_q_i values 0xA5A5A5A5 and 0x12345678.
- Full stall, DEPTH = 2:
  - Stimulus: two stb_acks with no ack, then a third request.
  - Required: biu_stb_o = 0.
  - After one ack, biu_stb_o = 1 in the same cycle the ack pops.
- Lock:
  - Stimulus: master 0 issues a locked access, then a final unlocked one, while master 1 requests continuously.
  - Required: master 1 gets no grant until the cycle after the unlocked stb_ack.
- Error and reset:
  - Error: biu_err_i on head = 1 → m_err_o[1] = 1 only.
  - Reset: rst_ni asserted with 2 outstanding → count = 0; a later ack produces no m_ack_o.
